load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the single-cycle datapath.
- Consumes the datapath's ALU result (as address), its store data and the load/store control, and drives a valid/ready data-memory bus.
- Returns sign/zero-extended load data to the datapath's result mux, and stalls the core while an access is outstanding.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+RESP before the access is abandoned with bus_err.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
mem_read  in  1  load requested by current instruction; held while stall=1
mem_write  in  1  store requested; write wins if both high
funct3  in  3  instr[14:12]; size/sign of access
addr  in  32  byte address (ALU result)
store_data  in  32  register rs2 value
load_data  out  32  aligned, extended load result (registered)
stall  out  1  core must hold PC/instr while high
misaligned  out  1  misaligned access detected (combinational, IDLE only)
bus_err  out  1  timeout or unsupported funct3; high exactly during DONE
bus_req_valid  out  1  request valid
bus_req_ready  in  1  memory accepts request
bus_we  out  1  1=write
bus_addr  out  32  {addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_wstrb  out  4  byte enables (0000 on reads)
bus_resp_valid  in  1  read data valid / write complete
bus_rdata  in  32  read word

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE, load_data=0, bus_err=0, timeout counter=0, bus_req_valid=0, bus_we=0, bus_wstrb=0.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - Request present, aligned, legal funct3: latch addr, store_data, funct3, we; counter:=0; go to REQ.
  - stall=1 combinationally in this cycle.
- IDLE, no request: stall=0 and state stays IDLE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value: go to DONE with bus_err=1, no bus access, load_data unchanged.
- Misaligned access:
  - Condition: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Response: misaligned=1, stall=0, no bus access, state stays IDLE, load_data unchanged.
- REQ:
  - bus_req_valid=1; all bus_* outputs held stable until bus_req_valid & bus_req_ready.
  - On handshake go to RESP.
  - bus_resp_valid is ignored in REQ.
- RESP:
  - bus_req_valid=0.
  - On bus_resp_valid, a load registers the extracted value into load_data; go to DONE.
- Load extraction:
  - Byte: bus_rdata[8*addr[1:0]+:8].
  - Half: bus_rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout:
  - Counter increments each cycle in REQ or RESP.
  - When counter reaches TIMEOUT-1 with no completing event, go to DONE: bus_err=1, load_data:=0, bus_req_valid drops.
- DONE:
  - stall=0 for one cycle, so the core retires the instruction on this edge.
  - bus_err is registered and high only here.
  - Next state is IDLE unconditionally; inputs are ignored in DONE.
- Stall: stall=1 in REQ and RESP, plus the IDLE issue cycle described above.
- Store formatting:
  - SB: wdata = byte replicated x4; wstrb = 0001<<addr[1:0].
  - SH: wdata = half replicated x2; wstrb = 0011<<(2*addr[1]).
  - SW: wdata = full word; wstrb = 1111.
- Store completion: stores also wait for bus_resp_valid; load_data is unchanged by stores.
- Latency: with zero-wait memory (ready=1, response the cycle after acceptance), an access takes 4 cycles (IDLE, REQ, RESP, DONE) with stall high for 3.
- Reset mid-access: state returns to IDLE at that edge and bus_req_valid=0 afterwards. A late bus_resp_valid is ignored.
- Back-to-back accesses: a new request is seen only in IDLE, at the earliest the cycle after DONE.

Test Plan:
- Zero-wait LW at addr 0x100, bus_rdata=0xDEADBEEF → bus_addr=0x100, wstrb=0000; stall high 3 cycles; load_data=0xDEADBEEF in DONE.
- LB at addr 0x103, rdata=0x80112233, then LBU at the same address → load_data=0xFFFFFF80, then 0x00000080.
- SH at addr 0x202, store_data=0x0000ABCD → bus_we=1, bus_addr=0x200, wdata=0xABCDABCD, wstrb=1100; stall until response.
- LW at addr 0x102 → misaligned=1, stall=0, no bus_req_valid, load_data unchanged.
- bus_req_ready held 0 with TIMEOUT=8 → DONE after 8 REQ cycles; bus_err=1 for one cycle; load_data=0; next state IDLE.
- reset asserted in RESP, then bus_resp_valid arrives → state IDLE, bus_req_valid=0, load_data=0; response ignored.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : load_store_unit_if                                     |
// | Description : Valid/ready data-memory bus between the load/store     |
// |               unit (master) and data memory (slave).                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface load_store_unit_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_resp_valid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req_valid,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_wstrb,
    input  bus_req_ready,
    input  bus_resp_valid,
    input  bus_rdata
  );

  modport slave (
    input  bus_req_valid,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_wstrb,
    output bus_req_ready,
    output bus_resp_valid,
    output bus_rdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : load_store_unit                                        |
// | Description : Memory-access stage. Turns the datapath's address,     |
// |               store data and load/store control into a valid/ready   |
// |               bus access, stalls the core while it is outstanding    |
// |               and returns aligned, extended load data.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_err,
  load_store_unit_if.master bus
);

  localparam int               c_CW    = $clog2(TIMEOUT + 1);
  localparam logic [c_CW-1:0]  c_LIMIT = c_CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [31:0]       r_addr;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [c_CW-1:0]   r_count;
  logic              r_bus_err;

  logic              w_req;
  logic              w_legal;
  logic              w_mis_cond;
  logic [31:0]       w_fmt_wdata;
  logic [3:0]        w_fmt_wstrb;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_value;

  logic              w_latch;
  logic              w_cnt_inc;
  logic              w_set_err;
  logic              w_capture;
  logic              w_clear_load;

  assign w_req = mem_read | mem_write;

  // Decode legality, alignment and store lane formatting of the incoming request; a write wins over a read.
  always_comb begin
    w_legal     = 1'b0;
    w_mis_cond  = 1'b0;
    w_fmt_wdata = store_data;
    w_fmt_wstrb = 4'b0000;
    if (mem_write) begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    w_mis_cond = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        w_fmt_wdata = {4{store_data[7:0]}};
        w_fmt_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        w_fmt_wdata = {2{store_data[15:0]}};
        w_fmt_wstrb = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        w_fmt_wdata = store_data;
        w_fmt_wstrb = 4'b1111;
      end
    endcase
    if (!mem_write) begin
      w_fmt_wstrb = 4'b0000;
    end
  end

  // Pick the addressed byte/halfword from the returned word and extend it.
  always_comb begin
    w_byte       = bus.bus_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half       = bus.bus_rdata[{r_addr[1], 4'b0000} +: 16];
    w_load_value = bus.bus_rdata;
    case (r_funct3)
      3'b000:  w_load_value = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_value = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_value = {24'd0, w_byte};
      3'b101:  w_load_value = {16'd0, w_half};
      default: w_load_value = bus.bus_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic, core-facing handshake outputs and datapath controls.
  // A handshake in the last allowed REQ cycle still moves to RESP, which
  // then gets a single cycle for its response before being abandoned.
  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_cnt_inc    = 1'b0;
    w_set_err    = 1'b0;
    w_capture    = 1'b0;
    w_clear_load = 1'b0;
    stall        = 1'b0;
    misaligned   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (!w_legal) begin
            w_next    = S_DONE;
            w_set_err = 1'b1;
            stall     = 1'b1;
          end else if (w_mis_cond) begin
            misaligned = 1'b1;
          end else begin
            w_next  = S_REQ;
            w_latch = 1'b1;
            stall   = 1'b1;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus.bus_req_ready) begin
          w_next    = S_RESP;
          w_cnt_inc = 1'b1;
        end else if (r_count >= c_LIMIT) begin
          w_next       = S_DONE;
          w_set_err    = 1'b1;
          w_clear_load = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RESP: begin
        stall = 1'b1;
        if (bus.bus_resp_valid) begin
          w_next    = S_DONE;
          w_capture = !r_we;
        end else if (r_count >= c_LIMIT) begin
          w_next       = S_DONE;
          w_set_err    = 1'b1;
          w_clear_load = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request capture, timeout counter, load result and error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= 32'd0;
      r_funct3  <= 3'd0;
      r_we      <= 1'b0;
      r_wdata   <= 32'd0;
      r_wstrb   <= 4'b0000;
      r_count   <= '0;
      r_bus_err <= 1'b0;
      load_data <= 32'd0;
    end else begin
      r_bus_err <= w_set_err;
      if (w_latch) begin
        r_addr   <= addr;
        r_funct3 <= funct3;
        r_we     <= mem_write;
        r_wdata  <= w_fmt_wdata;
        r_wstrb  <= w_fmt_wstrb;
        r_count  <= '0;
      end else if (w_cnt_inc) begin
        r_count <= r_count + c_CW'(1);
      end
      if (w_clear_load) begin
        load_data <= 32'd0;
      end else if (w_capture) begin
        load_data <= w_load_value;
      end
    end
  end

  assign bus.bus_req_valid = (r_state == S_REQ);
  assign bus.bus_we        = r_we;
  assign bus.bus_addr      = {r_addr[31:2], 2'b00};
  assign bus.bus_wdata     = r_wdata;
  assign bus.bus_wstrb     = r_wstrb;
  assign bus_err           = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                     |
// | Description : Self-checking bench for load_store_unit: directed      |
// |               vector table, random accesses against a reference      |
// |               model, reset-in-RESP and back-to-back sequences.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [31:0] load_data;
  logic        stall;
  logic        misaligned;
  logic        bus_err;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    int          rw;        // REQ cycles before ready is given
    int          pw;        // RESP cycles before response is given
    logic        exp_mis;
    logic        exp_err;
    logic        exp_we;
    int          exp_stall; // cycles with stall high
    int          exp_req;   // cycles with bus_req_valid high
    logic [31:0] exp_ld;
    logic [31:0] exp_baddr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_ld = 32'd0;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Reference model: what one access should do, from the access rules alone.
  function automatic vec_t model(input logic re, input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd, input int rw, input int pw,
                                 input logic [31:0] prev);
    vec_t        v;
    logic        legal;
    int          size;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] ext;
    v.re = re; v.we = we; v.f3 = f3; v.addr = a; v.sd = sd; v.rd = rd; v.rw = rw; v.pw = pw;
    legal = we ? (f3 == 0 || f3 == 1 || f3 == 2)
               : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    size  = int'(f3) % 4;
    v.exp_we    = we;
    v.exp_mis   = legal && ((size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0));
    v.exp_err   = 1'b0;
    v.exp_stall = 0;
    v.exp_req   = 0;
    v.exp_ld    = prev;
    v.exp_baddr = a - (a % 4);
    if (size == 0) begin
      v.exp_wdata = (sd & 32'hFF) * 32'h01010101;
      v.exp_wstrb = 4'(1 << (a % 4));
    end else if (size == 1) begin
      v.exp_wdata = (sd & 32'hFFFF) * 32'h00010001;
      v.exp_wstrb = 4'(3 << (2 * ((a / 2) % 2)));
    end else begin
      v.exp_wdata = sd;
      v.exp_wstrb = 4'hF;
    end
    if (!we) v.exp_wstrb = 4'h0;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    ext = (b >= 128) ? b - 32'd256 : b;
      3'd1:    ext = (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    ext = b;
      3'd5:    ext = h;
      default: ext = rd;
    endcase
    if (!legal) begin
      v.exp_err   = 1'b1;
      v.exp_stall = 1;
    end else if (!v.exp_mis) begin
      v.exp_req = (rw + 1 < TO) ? rw + 1 : TO;
      if (rw + pw + 2 <= TO) begin
        v.exp_stall = 1 + rw + pw + 2;
        if (!we) v.exp_ld = ext;
      end else begin
        v.exp_stall = 1 + TO;
        v.exp_err   = 1'b1;
        v.exp_ld    = 32'd0;
      end
    end
    return v;
  endfunction

  // Drive one access from an IDLE negedge and act as the memory; ends on a negedge in IDLE.
  task automatic run_access(input vec_t v, input string tag);
    int stall_cnt, req_cnt, resp_cnt, cyc;
    bit accepted, done;
    mem_read   = v.re;
    mem_write  = v.we;
    funct3     = v.f3;
    addr       = v.addr;
    store_data = v.sd;
    bus.bus_req_ready  = 1'b0;
    bus.bus_resp_valid = 1'b0;
    bus.bus_rdata      = $urandom;
    #1;
    chk1({tag, ".misaligned"}, misaligned, v.exp_mis);
    if (v.exp_mis) begin
      chk1({tag, ".mis_stall"}, stall, 1'b0);
      chk1({tag, ".mis_valid"}, bus.bus_req_valid, 1'b0);
      @(posedge clk); @(negedge clk);
      chk1({tag, ".mis_hold"}, misaligned, 1'b1);
      chk1({tag, ".mis_valid2"}, bus.bus_req_valid, 1'b0);
      chk({tag, ".mis_ld"}, load_data, v.exp_ld);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #1;
    end else begin
      stall_cnt = 0; req_cnt = 0; resp_cnt = 0; cyc = 0;
      accepted = 0; done = 0;
      while (!done && cyc < 400) begin
        cyc++;
        if (!stall && cyc > 1) begin
          done = 1;
          chk1({tag, ".bus_err"}, bus_err, v.exp_err);
          chk({tag, ".load_data"}, load_data, v.exp_ld);
          chk1({tag, ".done_valid"}, bus.bus_req_valid, 1'b0);
          mem_read  = 1'b0;
          mem_write = 1'b0;
          bus.bus_req_ready  = 1'b0;
          bus.bus_resp_valid = 1'b0;
        end else begin
          if (stall) stall_cnt++;
          if (bus.bus_req_valid) begin
            req_cnt++;
            chk({tag, ".bus_addr"}, bus.bus_addr, v.exp_baddr);
            chk1({tag, ".bus_we"}, bus.bus_we, v.exp_we);
            chk({tag, ".bus_wstrb"}, 32'(bus.bus_wstrb), 32'(v.exp_wstrb));
            if (v.exp_we) chk({tag, ".bus_wdata"}, bus.bus_wdata, v.exp_wdata);
            if (req_cnt > v.rw) begin
              bus.bus_req_ready  = 1'b1;
              bus.bus_resp_valid = 1'b0;
              accepted = 1;
            end else begin
              bus.bus_req_ready  = 1'b0;
              bus.bus_resp_valid = 1'($urandom_range(0, 1));
              bus.bus_rdata      = $urandom;
            end
          end else if (accepted) begin
            resp_cnt++;
            bus.bus_req_ready = 1'b0;
            if (resp_cnt > v.pw) begin
              bus.bus_resp_valid = 1'b1;
              bus.bus_rdata      = v.rd;
            end else begin
              bus.bus_resp_valid = 1'b0;
              bus.bus_rdata      = $urandom;
            end
          end
          @(posedge clk); @(negedge clk);
        end
      end
      if (!done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s.complete: got no DONE within 400 cycles, want completion", tag);
      end
      chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
      chk({tag, ".req_cycles"}, 32'(req_cnt), 32'(v.exp_req));
      @(posedge clk); @(negedge clk);
      chk1({tag, ".idle_stall"}, stall, 1'b0);
      chk1({tag, ".idle_err"}, bus_err, 1'b0);
      chk1({tag, ".idle_valid"}, bus.bus_req_valid, 1'b0);
      chk({tag, ".idle_ld"}, load_data, v.exp_ld);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ld_f3 [5];
    logic [2:0]  st_f3 [3];
    vec_t        v;
    logic        r, w;
    logic [2:0]  f;
    logic [31:0] a;
    int          op, rw, pw;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    st_f3 = '{3'd0, 3'd1, 3'd2};

    bus.bus_req_ready  = 1'b0;
    bus.bus_resp_valid = 1'b0;
    bus.bus_rdata      = 32'd0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("rst.valid", bus.bus_req_valid, 1'b0);
    chk1("rst.stall", stall, 1'b0);
    chk1("rst.bus_we", bus.bus_we, 1'b0);
    chk("rst.wstrb", 32'(bus.bus_wstrb), 32'd0);
    chk("rst.load_data", load_data, 32'd0);
    chk1("rst.bus_err", bus_err, 1'b0);
    chk1("rst.misaligned", misaligned, 1'b0);
    @(negedge clk);

    // ---- directed vectors: re we f3 addr sd rd rw pw | mis err we stall req ld baddr wdata wstrb ----
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0,
                    1'b0, 1'b0, 1'b0, 3, 1, 32'hDEADBEEF, 32'h100, 32'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, 0,
                    1'b0, 1'b0, 1'b0, 3, 1, 32'hFFFFFF80, 32'h100, 32'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 0, 0,
                    1'b0, 1'b0, 1'b0, 3, 1, 32'h00000080, 32'h100, 32'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 0, 0,
                    1'b0, 1'b0, 1'b1, 3, 1, 32'h00000080, 32'h200, 32'hABCDABCD, 4'hC});
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0,
                    1'b1, 1'b0, 1'b0, 0, 0, 32'h00000080, 32'h0, 32'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h80017FFF, 0, 0,
                    1'b0, 1'b0, 1'b0, 3, 1, 32'hFFFF8001, 32'h100, 32'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd5, 32'h100, 32'h0, 32'h80017FFF, 0, 0,
                    1'b0, 1'b0, 1'b0, 3, 1, 32'h00007FFF, 32'h100, 32'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd0, 32'h101, 32'h123456A5, 32'h0, 0, 0,
                    1'b0, 1'b0, 1'b1, 3, 1, 32'h00007FFF, 32'h100, 32'hA5A5A5A5, 4'h2});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0, 0, 0,
                    1'b0, 1'b0, 1'b1, 3, 1, 32'h00007FFF, 32'h300, 32'hCAFEF00D, 4'hF});
    tbl.push_back('{1'b1, 1'b0, 3'd3, 32'h400, 32'h0, 32'h0, 0, 0,
                    1'b0, 1'b1, 1'b0, 1, 0, 32'h00007FFF, 32'h0, 32'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd4, 32'h404, 32'h0, 32'h0, 0, 0,
                    1'b0, 1'b1, 1'b1, 1, 0, 32'h00007FFF, 32'h0, 32'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 0,
                    1'b1, 1'b0, 1'b0, 0, 0, 32'h00007FFF, 32'h0, 32'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 32'h0000007F, 2, 1,
                    1'b0, 1'b0, 1'b0, 6, 3, 32'h0000007F, 32'h100, 32'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h10C, 32'h0, 32'h13579BDF, 3, 2,
                    1'b0, 1'b0, 1'b0, 8, 4, 32'h13579BDF, 32'h10C, 32'h0, 4'h0});
    // response never arrives in time: timeout in RESP
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h030, 32'h0, 32'h0, 2, 6,
                    1'b0, 1'b1, 1'b0, 9, 3, 32'h0, 32'h030, 32'h0, 4'h0});
    tbl.push_back('{1'b1, 1'b0, 3'd4, 32'h102, 32'h0, 32'h00C30000, 0, 0,
                    1'b0, 1'b0, 1'b0, 3, 1, 32'h000000C3, 32'h100, 32'h0, 4'h0});
    // ready held low: abandoned after TO REQ cycles, load_data cleared
    tbl.push_back('{1'b1, 1'b0, 3'd2, 32'h110, 32'h0, 32'h0, 100, 0,
                    1'b0, 1'b1, 1'b0, 9, 8, 32'h0, 32'h110, 32'h0, 4'h0});
    tbl.push_back('{1'b0, 1'b1, 3'd0, 32'h003, 32'h000000FF, 32'h0, 1, 1,
                    1'b0, 1'b0, 1'b1, 5, 2, 32'h0, 32'h0, 32'hFFFFFFFF, 4'h8});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'h020, 32'h01020304, 32'h0, 0, 0,
                    1'b0, 1'b0, 1'b1, 3, 1, 32'h0, 32'h020, 32'h01020304, 4'hF});
    for (int i = 0; i < tbl.size(); i++) begin
      run_access(tbl[i], $sformatf("vec%0d", i));
      model_ld = tbl[i].exp_ld;
    end

    // ---- randomized accesses against the reference model ----
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      r  = (op < 5) || (op == 9);
      w  = (op >= 5);
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        f = 3'($urandom_range(0, 7));
        a[1:0] = 2'b00;
      end else begin
        f = w ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
        if ($urandom_range(0, 2) != 0) begin
          if (f[1:0] == 2'b01) a[0] = 1'b0;
          if (f[1:0] == 2'b10) a[1:0] = 2'b00;
        end
      end
      rw = ($urandom_range(0, 9) == 0) ? 10 : $urandom_range(0, 3);
      pw = $urandom_range(0, 4);
      v  = model(r, w, f, a, $urandom, $urandom, rw, pw, model_ld);
      run_access(v, $sformatf("rnd%0d", i));
      model_ld = v.exp_ld;
    end

    // ---- reset in RESP, then a late response ----
    v = model(1'b1, 1'b0, 3'd2, 32'h600, 32'h0, 32'h11111111, 0, 0, model_ld);
    run_access(v, "pre_rst");
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h500;
    @(posedge clk); @(negedge clk);
    chk1("rst_resp.req_valid", bus.bus_req_valid, 1'b1);
    bus.bus_req_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk1("rst_resp.in_resp_stall", stall, 1'b1);
    bus.bus_req_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    mem_read = 1'b0;
    bus.bus_resp_valid = 1'b1;
    bus.bus_rdata      = 32'hFFFFFFFF;
    #1;
    chk1("rst_resp.valid", bus.bus_req_valid, 1'b0);
    chk1("rst_resp.stall", stall, 1'b0);
    chk("rst_resp.load_data", load_data, 32'd0);
    @(posedge clk); @(negedge clk);
    bus.bus_resp_valid = 1'b0;
    chk("rst_resp.late_ld", load_data, 32'd0);
    chk1("rst_resp.late_err", bus_err, 1'b0);
    chk1("rst_resp.late_stall", stall, 1'b0);
    model_ld = 32'd0;

    // ---- back-to-back: request held through DONE is re-issued from IDLE ----
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'd2; addr = 32'h700;
    #1;
    chk1("b2b.issue_stall", stall, 1'b1);
    @(posedge clk); @(negedge clk);
    bus.bus_req_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.bus_req_ready  = 1'b0;
    bus.bus_resp_valid = 1'b1;
    bus.bus_rdata      = 32'hA5A50001;
    @(posedge clk); @(negedge clk);
    bus.bus_resp_valid = 1'b0;
    chk1("b2b.done_stall", stall, 1'b0);
    chk1("b2b.done_valid", bus.bus_req_valid, 1'b0);
    chk("b2b.first_ld", load_data, 32'hA5A50001);
    @(posedge clk); @(negedge clk);
    chk1("b2b.reissue_stall", stall, 1'b1);
    chk1("b2b.reissue_valid", bus.bus_req_valid, 1'b0);
    @(posedge clk); @(negedge clk);
    chk1("b2b.req2_valid", bus.bus_req_valid, 1'b1);
    chk("b2b.req2_addr", bus.bus_addr, 32'h700);
    bus.bus_req_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.bus_req_ready  = 1'b0;
    bus.bus_resp_valid = 1'b1;
    bus.bus_rdata      = 32'h5A5A0002;
    @(posedge clk); @(negedge clk);
    bus.bus_resp_valid = 1'b0;
    mem_read = 1'b0;
    chk("b2b.second_ld", load_data, 32'h5A5A0002);
    @(posedge clk); @(negedge clk);
    chk1("b2b.final_stall", stall, 1'b0);
    chk1("b2b.final_valid", bus.bus_req_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
